d_ff_tristate: RTL and testbench

- Positive-edge D-type storage register with an asynchronous active-low clear and a tri-state output driver.
- Used as a bus-attachable latch stage: it captures `data` on every rising clock edge.
- It presents the stored value on `Q` only while `outputEnable` is high; otherwise it releases the line (high-Z).
- Storage and output gating are independent, so the register keeps tracking `data` while its output is disabled.

---
 rtl/d_ff_tristate.sv | 27 ++
 tb/tb_d_ff_tristate.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/d_ff_tristate.sv
// rtl/d_ff_tristate.sv - D register with async active-low clear and tri-state output
module d_ff_tristate #(
   parameter int unsigned           WIDTH       = 1,
   parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data,
   input  logic             outputEnable,
   output wire  [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] storage;

   // Capture data on every rising edge; clear immediately while rst is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         storage <= RESET_VALUE;
      end else begin
         storage <= data;
      end
   end

   // Output gating is combinational and independent of storage updates.
   assign Q = outputEnable ? storage : {WIDTH{1'bz}};

endmodule

// File: tb/tb_d_ff_tristate.sv
// tb/tb_d_ff_tristate.sv - table-driven scoreboard bench for d_ff_tristate
module tb_d_ff_tristate;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       oe  = 1'b0;
   logic [7:0] data = 8'h00;

   // Each width is instantiated twice: one output net pulled up, one pulled
   // down. A released output reads all-ones on the first and all-zeros on the
   // second, while a driven output reads the same value on both.
   tri1 [7:0] q8_up;
   tri0 [7:0] q8_dn;
   tri1       q1_up;
   tri0       q1_dn;

   d_ff_tristate #(.WIDTH(8), .RESET_VALUE(8'h3C)) u_dut8_up (
      .clk(clk), .rst(rst), .data(data), .outputEnable(oe), .Q(q8_up));
   d_ff_tristate #(.WIDTH(8), .RESET_VALUE(8'h3C)) u_dut8_dn (
      .clk(clk), .rst(rst), .data(data), .outputEnable(oe), .Q(q8_dn));
   d_ff_tristate #(.WIDTH(1)) u_dut1_up (
      .clk(clk), .rst(rst), .data(data[0]), .outputEnable(oe), .Q(q1_up));
   d_ff_tristate #(.WIDTH(1)) u_dut1_dn (
      .clk(clk), .rst(rst), .data(data[0]), .outputEnable(oe), .Q(q1_dn));

   typedef struct {
      logic       rst;
      logic       oe;
      logic [7:0] d;
      logic       pulse;
      logic       expz;
      logic [7:0] exp;
   } vec_t;

   typedef struct {
      string      name;
      logic       z;
      logic [7:0] v;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic push_exp(input string name, input logic z, input logic [7:0] v);
      exp_t e;
      e.name = name;
      e.z    = z;
      e.v    = v;
      sb.push_back(e);
   endtask

   // Pops one expectation and compares both widths against it.
   task automatic check_pop();
      exp_t e;
      logic ok8;
      logic ok1;
      if (sb.size() == 0) begin
         n_checks++;
         $display("FAIL scoreboard_empty: got 0 entries, need 1");
         return;
      end
      e = sb.pop_front();
      if (e.z) begin
         ok8 = (q8_up === 8'hFF) && (q8_dn === 8'h00);
         ok1 = (q1_up === 1'b1) && (q1_dn === 1'b0);
      end else begin
         ok8 = (q8_up === e.v) && (q8_dn === e.v);
         ok1 = (q1_up === e.v[0]) && (q1_dn === e.v[0]);
      end
      n_checks++;
      if (ok8) n_pass++;
      else $display("FAIL %s w8: got up=%h dn=%h, need %s", e.name, q8_up, q8_dn,
                    e.z ? "Z" : $sformatf("%h", e.v));
      n_checks++;
      if (ok1) n_pass++;
      else $display("FAIL %s w1: got up=%b dn=%b, need %s", e.name, q1_up, q1_dn,
                    e.z ? "Z" : $sformatf("%b", e.v[0]));
   endtask

   task automatic add(input logic r, input logic o, input logic [7:0] d,
                      input logic p, input logic z, input logic [7:0] x);
      vec_t v;
      v.rst = r; v.oe = o; v.d = d; v.pulse = p; v.expz = z; v.exp = x;
      vecs.push_back(v);
   endtask

   initial begin
      // rst  oe  data  pulse expz exp
      add(0, 1, 8'h00, 0, 0, 8'h3C);   // async clear, no clock
      add(0, 1, 8'hFF, 1, 0, 8'h3C);   // edge ignored in reset
      add(1, 1, 8'h00, 1, 0, 8'h00);   // capture path
      add(1, 1, 8'h01, 1, 0, 8'h01);
      add(1, 1, 8'h00, 1, 0, 8'h00);
      add(1, 1, 8'hA5, 1, 0, 8'hA5);
      add(0, 1, 8'hA5, 0, 0, 8'h3C);   // async reset from stored value
      add(0, 1, 8'hFF, 1, 0, 8'h3C);
      add(1, 1, 8'hFF, 1, 0, 8'hFF);   // release then capture
      add(1, 0, 8'h00, 0, 1, 8'h00);   // disabled -> Z
      add(1, 0, 8'h5A, 1, 1, 8'h00);   // capture while disabled
      add(1, 1, 8'h00, 0, 0, 8'h5A);   // re-enable shows last capture
      add(1, 0, 8'hC3, 1, 1, 8'h00);
      add(1, 1, 8'hC3, 0, 0, 8'hC3);
      add(0, 0, 8'hFF, 1, 1, 8'h00);   // reset while disabled
      add(0, 1, 8'hFF, 0, 0, 8'h3C);   // re-enable in reset
      add(1, 1, 8'h96, 1, 0, 8'h96);

      #1 rst = 1'b0;
      #2;

      for (int i = 0; i < vecs.size(); i++) begin
         push_exp($sformatf("vec%0d", i), vecs[i].expz, vecs[i].exp);
         rst  = vecs[i].rst;
         oe   = vecs[i].oe;
         data = vecs[i].d;
         #2;
         if (vecs[i].pulse) begin
            clk = 1'b1;
            #2;
            check_pop();
            clk = 1'b0;
            #2;
         end else begin
            check_pop();
         end
      end

      // Inter-edge and falling-edge immunity with a multi-bit value.
      rst = 1'b1; oe = 1'b1; data = 8'hA5;
      #2;
      push_exp("imm_rise", 0, 8'hA5);
      clk = 1'b1;
      #2 check_pop();
      push_exp("imm_high_chg", 0, 8'hA5);
      data = 8'h00;
      #2 check_pop();
      push_exp("imm_fall", 0, 8'hA5);
      clk = 1'b0;
      #2 check_pop();
      push_exp("imm_low_chg", 0, 8'hA5);
      data = 8'hFF;
      #2 check_pop();
      push_exp("imm_next_rise", 0, 8'h3C);
      data = 8'h3C;
      #2 clk = 1'b1;
      #2 check_pop();
      clk = 1'b0;
      // Zero-latency output disable/enable with clock idle.
      push_exp("oe_off_idle", 1, 8'h00);
      #2 oe = 1'b0;
      #1 check_pop();
      push_exp("oe_on_idle", 0, 8'h3C);
      oe = 1'b1;
      #1 check_pop();

      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: got %0d left, need 0", sb.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
